// File: rtl/u41_norm_seq.sv
// Finds the NPN-style input-permutation canonical form of a 4-input truth table.
// One candidate permutation is evaluated per clock through a shared permute unit and comparator.
module u41_norm_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] func,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] norm,
    output logic [7:0]  perm,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [15:0] func_q;
    logic [15:0] best;
    logic [7:0]  best_perm;
    logic [7:0]  cur_perm;
    logic [15:0] cand;
    logic        take;

    // Lexicographic list of the 24 permutations, f0 in the top field.
    function automatic logic [7:0] perm_at(input logic [4:0] k);
        logic [7:0] p;
        case (k)
            5'd0:  p = 8'h1B;  5'd1:  p = 8'h1E;  5'd2:  p = 8'h27;  5'd3:  p = 8'h2D;
            5'd4:  p = 8'h36;  5'd5:  p = 8'h39;  5'd6:  p = 8'h4B;  5'd7:  p = 8'h4E;
            5'd8:  p = 8'h63;  5'd9:  p = 8'h6C;  5'd10: p = 8'h72;  5'd11: p = 8'h78;
            5'd12: p = 8'h87;  5'd13: p = 8'h8D;  5'd14: p = 8'h93;  5'd15: p = 8'h9C;
            5'd16: p = 8'hB1;  5'd17: p = 8'hB4;  5'd18: p = 8'hC6;  5'd19: p = 8'hC9;
            5'd20: p = 8'hD2;  5'd21: p = 8'hD8;  5'd22: p = 8'hE1;  5'd23: p = 8'hE4;
            default: p = 8'h1B;
        endcase
        return p;
    endfunction

    // Output bit i reads the source row whose bit f_t carries input bit t.
    function automatic logic [15:0] permute(input logic [15:0] f, input logic [7:0] p);
        logic [15:0] r;
        logic [3:0]  src;
        logic [3:0]  row;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            row = 4'(i);
            src = '0;
            for (int t = 0; t < 4; t++) begin
                src[p[7-2*t -: 2]] = row[t];
            end
            r[i] = f[src];
        end
        return r;
    endfunction

    always_comb begin
        cur_perm = perm_at(idx);
        cand     = permute(func_q, cur_perm);
        take     = (idx == 5'd0) || (cand < best);
    end

    assign in_ready = (state == IDLE) && !rst;

    // Strict less-than keeps the earliest permutation on ties; result registers load only on the final scan edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            func_q    <= '0;
            best      <= '0;
            best_perm <= '0;
            norm      <= '0;
            perm      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        func_q <= func;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best      <= cand;
                        best_perm <= cur_perm;
                    end
                    idx <= idx + 5'd1;
                    if (idx == 5'd23) begin
                        norm      <= take ? cand : best;
                        perm      <= take ? cur_perm : best_perm;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
